// File: rtl/shuffle_pkg.sv
// shuffle_pkg: shared state type, move counter width and LFSR tap table
// for the shuffle/solve game controller and the puzzle's random-fill block.
package shuffle_pkg;
    localparam int MOVES_W = 8;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCRAMBLE = 2'd1,
        PLAY     = 2'd2,
        SOLVED   = 2'd3
    } state_e;
    // Galois (right-shift) feedback masks of primitive polynomials, bit n-1 always set.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            3:       lfsr_taps = 16'h0006;
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            7:       lfsr_taps = 16'h0060;
            8:       lfsr_taps = 16'h00B8;
            9:       lfsr_taps = 16'h0110;
            10:      lfsr_taps = 16'h0240;
            11:      lfsr_taps = 16'h0500;
            12:      lfsr_taps = 16'h0829;
            13:      lfsr_taps = 16'h100D;
            14:      lfsr_taps = 16'h2015;
            15:      lfsr_taps = 16'h6000;
            16:      lfsr_taps = 16'hD008;
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction
endpackage

// File: rtl/shuffle_solve_ctrl_if.sv
// shuffle_solve_ctrl_if: move handshake between the game controller (master)
// and the board move engine (slave).
interface shuffle_solve_ctrl_if #(parameter int RAND_W = 5);
    import shuffle_pkg::*;
    logic               move_valid;
    logic               move_ready;
    logic [RAND_W-1:0]  move_idx;
    logic [MOVES_W-1:0] moves_left;
    modport master (output move_valid, move_idx, moves_left, input move_ready);
    modport slave  (input move_valid, move_idx, moves_left, output move_ready);
endinterface

// File: rtl/shuffle_solve_ctrl_lfsr_gen.sv
// lfsr_gen: maximal-length Galois LFSR for WIDTH 3..16; a zero SEED is
// replaced by all-ones so the register can never lock up at zero.
module lfsr_gen
    import shuffle_pkg::*;
#(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_V = (SEED == '0) ? '1 : SEED;
    logic [WIDTH-1:0] value_q, value_d;
    assign value_d = en ? ((value_q >> 1) ^ (value_q[0] ? TAPS : '0)) : value_q;
    assign value   = value_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= SEED_V;
        else        value_q <= value_d;
    end
endmodule

// File: rtl/shuffle_solve_ctrl.sv
// shuffle_solve_ctrl: game-mode sequencer IDLE -> SCRAMBLE -> PLAY -> SOLVED;
// issues random board moves over valid/ready and drives the solve buzzer.
module shuffle_solve_ctrl
    import shuffle_pkg::*;
#(
    parameter int                RAND_W      = 5,
    parameter int                MOVE_MAX    = 31,
    parameter int                NUM_MOVES   = 16,
    parameter int                BUZZ_CYCLES = 8,
    parameter logic [RAND_W-1:0] SEED        = '1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mix_state_i,
    input  logic                        scramble_btn_i,
    input  logic                        solved_i,
    shuffle_solve_ctrl_if.master        mv,
    output logic                        busy_o,
    output logic                        buzz_o,
    output logic [1:0]                  state_o
);
    localparam int                  BUZZ_W = $clog2(BUZZ_CYCLES + 1);
    localparam logic [MOVES_W-1:0]  NUM_L  = MOVES_W'(NUM_MOVES);
    localparam logic [BUZZ_W-1:0]   BUZZ_L = BUZZ_W'(BUZZ_CYCLES);
    localparam logic [RAND_W-1:0]   MAX_V  = RAND_W'(MOVE_MAX);
    state_e              state_q;
    logic [MOVES_W-1:0]  left_q;
    logic [BUZZ_W-1:0]   buzz_cnt_q;
    logic                busy_q, buzz_q;
    logic                sync1_q, sync2_q, edge_q;
    logic [RAND_W-1:0]   lfsr, cand_q, cand_d;
    logic                cand_ok_q;
    logic                btn_rise, xfer, hold;
    lfsr_gen #(.WIDTH(RAND_W), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .value (lfsr)
    );
    // The LFSR never yields zero; offset by one so index 0 is reachable.
    assign cand_d        = lfsr - RAND_W'(1);
    assign btn_rise      = sync2_q & ~edge_q;
    assign mv.move_valid = cand_ok_q && state_q == SCRAMBLE && left_q != '0;
    assign mv.move_idx   = cand_q;
    assign mv.moves_left = left_q;
    assign xfer          = mv.move_valid && mv.move_ready;
    assign hold          = mv.move_valid && !mv.move_ready;
    assign busy_o        = busy_q;
    assign buzz_o        = buzz_q;
    assign state_o       = state_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            edge_q    <= 1'b0;
            cand_q    <= '0;
            cand_ok_q <= 1'b0;
        end else begin
            sync1_q <= scramble_btn_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            if (!hold) begin
                cand_q    <= cand_d;
                cand_ok_q <= cand_d <= MAX_V;
            end
        end
    end
    // Mode switch off overrides every transition and aborts any pending move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            left_q     <= '0;
            buzz_cnt_q <= '0;
            busy_q     <= 1'b0;
            buzz_q     <= 1'b0;
        end else if (!mix_state_i) begin
            state_q    <= IDLE;
            left_q     <= '0;
            buzz_cnt_q <= '0;
            busy_q     <= 1'b0;
            buzz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (btn_rise) begin
                    state_q <= SCRAMBLE;
                    left_q  <= NUM_L;
                    busy_q  <= 1'b1;
                end
                SCRAMBLE: if (xfer) begin
                    left_q <= left_q - 1'b1;
                    if (left_q == MOVES_W'(1)) begin
                        state_q <= PLAY;
                        busy_q  <= 1'b0;
                    end
                end
                PLAY: if (solved_i) begin
                    state_q    <= SOLVED;
                    buzz_cnt_q <= BUZZ_L;
                    buzz_q     <= 1'b1;
                end else if (btn_rise) begin
                    state_q <= SCRAMBLE;
                    left_q  <= NUM_L;
                    busy_q  <= 1'b1;
                end
                SOLVED: begin
                    buzz_cnt_q <= buzz_cnt_q - 1'b1;
                    if (buzz_cnt_q == BUZZ_W'(1)) begin
                        state_q <= IDLE;
                        buzz_q  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shuffle_solve_ctrl.sv
// tb_shuffle_solve_ctrl: directed checks of the game controller; instance A uses
// default parameters, instance B restricts moves to 0..11 over 200 moves.
module tb_shuffle_solve_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mix_a = 1'b0, btn_a = 1'b0, solved_a = 1'b0, busy_a, buzz_a;
    logic       mix_b = 1'b0, btn_b = 1'b0, solved_b = 1'b0, busy_b, buzz_b;
    logic [1:0] st_a, st_b;
    int         checks = 0, errors = 0;
    logic [31:0] seen, seen_b;
    logic [4:0]  idx0, held;
    int          n, nb;
    logic        stalled;

    shuffle_solve_ctrl_if #(.RAND_W(5)) ifa ();
    shuffle_solve_ctrl_if #(.RAND_W(5)) ifb ();

    shuffle_solve_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .mix_state_i(mix_a), .scramble_btn_i(btn_a),
        .solved_i(solved_a), .mv(ifa.master), .busy_o(busy_a), .buzz_o(buzz_a), .state_o(st_a)
    );
    shuffle_solve_ctrl #(.RAND_W(5), .MOVE_MAX(11), .NUM_MOVES(200)) u_b (
        .clk(clk), .rst_n(rst_n), .mix_state_i(mix_b), .scramble_btn_i(btn_b),
        .solved_i(solved_b), .mv(ifb.master), .busy_o(busy_b), .buzz_o(buzz_b), .state_o(st_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_a(input logic [1:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && st_a !== s; i++) @(negedge clk);
        chk(tag, 32'(st_a), 32'(s));
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_state"}, 32'(st_a), 32'd0);
        chk({tag, "_valid"}, 32'(ifa.move_valid), 32'd0);
        chk({tag, "_idx"},   32'(ifa.move_idx), 32'd0);
        chk({tag, "_left"},  32'(ifa.moves_left), 32'd0);
        chk({tag, "_busy"},  32'(busy_a), 32'd0);
        chk({tag, "_buzz"},  32'(buzz_a), 32'd0);
    endtask

    initial begin
        ifa.move_ready = 1'b1;
        ifb.move_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_a("rst");
        rst_n = 1'b1;
        @(negedge clk);
        mix_a = 1'b1;
        @(negedge clk);
        // Button to scramble entry: state changes on the third edge
        btn_a = 1'b1;
        @(negedge clk); chk("lat1_state", 32'(st_a), 32'd0);
        @(negedge clk); chk("lat2_state", 32'(st_a), 32'd0);
        @(negedge clk); chk("lat3_state", 32'(st_a), 32'd1);
        chk("lat3_busy", 32'(busy_a), 32'd1);
        btn_a = 1'b0;
        // Ready tied high: one transfer per cycle, 16 distinct indices
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            chk("t2_valid", 32'(ifa.move_valid), 32'd1);
            chk("t2_left", 32'(ifa.moves_left), 32'(16 - i));
            chk("t2_unique", 32'(seen[ifa.move_idx]), 32'd0);
            seen[ifa.move_idx] = 1'b1;
            @(negedge clk);
        end
        chk("t2_state", 32'(st_a), 32'd2);
        chk("t2_busy", 32'(busy_a), 32'd0);
        chk("t2_valid_end", 32'(ifa.move_valid), 32'd0);
        chk("t2_left_end", 32'(ifa.moves_left), 32'd0);
        // Solve: buzzer for exactly 8 cycles, then IDLE
        solved_a = 1'b1;
        @(negedge clk);
        chk("t5_state", 32'(st_a), 32'd3);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (buzz_a) n++;
            @(negedge clk);
        end
        chk("t5_buzz_len", 32'(n), 32'd8);
        chk("t5_idle", 32'(st_a), 32'd0);
        solved_a = 1'b0;
        // Stall: valid/index/count hold for 10 cycles without ready
        ifa.move_ready = 1'b0;
        btn_a = 1'b1;
        wait_a(2'd1, 10, "t3_enter");
        btn_a = 1'b0;
        chk("t3_valid0", 32'(ifa.move_valid), 32'd1);
        idx0 = ifa.move_idx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(ifa.move_valid), 32'd1);
            chk("t3_hold_idx", 32'(ifa.move_idx), 32'(idx0));
            chk("t3_hold_left", 32'(ifa.moves_left), 32'd16);
        end
        ifa.move_ready = 1'b1;
        @(negedge clk);
        chk("t3_left_dec", 32'(ifa.moves_left), 32'd15);
        // Abort after 5 transfers, then a fresh scramble of 16
        repeat (4) @(negedge clk);
        chk("t6_left5", 32'(ifa.moves_left), 32'd11);
        mix_a = 1'b0;
        @(negedge clk);
        chk("t6_state", 32'(st_a), 32'd0);
        chk("t6_valid", 32'(ifa.move_valid), 32'd0);
        chk("t6_left", 32'(ifa.moves_left), 32'd0);
        chk("t6_busy", 32'(busy_a), 32'd0);
        mix_a = 1'b1;
        btn_a = 1'b1;
        wait_a(2'd1, 10, "t6_reenter");
        btn_a = 1'b0;
        chk("t6_fresh_left", 32'(ifa.moves_left), 32'd16);
        n = 0;
        for (int i = 0; i < 40 && st_a == 2'd1; i++) begin
            if (ifa.move_valid && ifa.move_ready) n++;
            @(negedge clk);
        end
        chk("t6_xfers", 32'(n), 32'd16);
        chk("t6_play", 32'(st_a), 32'd2);
        // Solved and button edge in the same cycle: solved wins
        btn_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        solved_a = 1'b1;
        @(negedge clk);
        chk("t5b_state", 32'(st_a), 32'd3);
        chk("t5b_buzz", 32'(buzz_a), 32'd1);
        btn_a = 1'b0;
        solved_a = 1'b0;
        wait_a(2'd0, 12, "t5b_idle");
        // Asynchronous reset while a move is pending
        ifa.move_ready = 1'b0;
        btn_a = 1'b1;
        wait_a(2'd1, 10, "t1_enter");
        btn_a = 1'b0;
        chk("t1_valid_pre", 32'(ifa.move_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_a("t1_async");
        @(negedge clk);
        rst_n = 1'b1;
        ifa.move_ready = 1'b1;
        // Instance B: 200 moves restricted to 0..11 with periodic stalls
        mix_b = 1'b1;
        @(negedge clk);
        btn_b = 1'b1;
        for (int i = 0; i < 10 && st_b !== 2'd1; i++) @(negedge clk);
        chk("t4_enter", 32'(st_b), 32'd1);
        btn_b = 1'b0;
        seen_b = '0;
        nb = 0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 3000 && nb < 200; c++) begin
            if (stalled) begin
                chk("t4_hold_valid", 32'(ifb.move_valid), 32'd1);
                chk("t4_hold_idx", 32'(ifb.move_idx), 32'(held));
            end
            chk("t4_left", 32'(ifb.moves_left), 32'(200 - nb));
            ifb.move_ready = (c % 3 != 2);
            stalled = 1'b0;
            if (ifb.move_valid) begin
                if (ifb.move_ready) begin
                    chk("t4_range", 32'(ifb.move_idx <= 5'd11), 32'd1);
                    seen_b[ifb.move_idx] = 1'b1;
                    nb++;
                end else begin
                    stalled = 1'b1;
                    held = ifb.move_idx;
                end
            end
            @(negedge clk);
        end
        chk("t4_count", 32'(nb), 32'd200);
        chk("t4_play", 32'(st_b), 32'd2);
        for (int v = 0; v < 12; v++) chk($sformatf("t4_seen_%0d", v), 32'(seen_b[v]), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
